// File: rtl/key_event_decoder.sv
// key_event_decoder: turns debounced key transitions into short-press, long-press and double-click pulses (plus auto-repeat when KEY_EVENT_REPEAT_EN is defined).
// Latency: every result is a registered pulse, high in the cycle after the deciding key event or terminal count.
// Backpressure: none; key_flag is a one-cycle strobe and every output pulse is fire-and-forget.
module key_event_decoder #(
  parameter int LONG_CNT    = 50_000_000,
  parameter int DBL_GAP_CNT = 12_500_000,
  parameter int REPEAT_CNT  = 10_000_000,
  parameter int CNT_W       = 26
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_flag,
  input  logic key_state,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic repeat_pulse,
  output logic key_busy
);

  // One-hot so that any corrupted encoding lands in the default branch.
  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    PRESS1    = 5'b00010,
    GAP       = 5'b00100,
    PRESS2    = 5'b01000,
    LONG_HOLD = 5'b10000
  } state_t;

  // Terminal counts: cnt starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CNT - 1);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             press_ev;
  logic             rel_ev;

  // key_state is only meaningful while key_flag is high; 0 means pressed.
  assign press_ev = key_flag & ~key_state;
  assign rel_ev   = key_flag &  key_state;

`ifndef KEY_EVENT_REPEAT_EN
  // No repeat logic in this build. REPEAT_CNT is always >= 1, so this is a constant 0;
  // it is referenced only so both builds share one parameter list.
  assign repeat_pulse = 1'b0 && (REPEAT_CNT < 1);
`endif

  // Gesture FSM with counter and registered pulse / busy outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      key_busy     <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_pulse <= 1'b0;
`endif
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
      repeat_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (press_ev) begin
            state    <= PRESS1;
            key_busy <= 1'b1;
          end else begin
            key_busy <= 1'b0;
          end
        end

        // First press held: a release always beats the long-press terminal count.
        PRESS1: begin
          key_busy <= 1'b1;
          if (rel_ev) begin
            state <= GAP;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG_HOLD;
            cnt        <= '0;
            long_press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Waiting for a possible second click: a press beats the gap timeout.
        GAP: begin
          if (press_ev) begin
            state    <= PRESS2;
            cnt      <= '0;
            key_busy <= 1'b1;
          end else if (cnt == GAP_LAST) begin
            state       <= IDLE;
            cnt         <= '0;
            short_press <= 1'b1;
            key_busy    <= 1'b0;
          end else begin
            cnt      <= cnt + CNT_ONE;
            key_busy <= 1'b1;
          end
        end

        // Second press: no timing, the release alone completes the double click.
        PRESS2: begin
          cnt <= '0;
          if (rel_ev) begin
            state        <= IDLE;
            double_click <= 1'b1;
            key_busy     <= 1'b0;
          end else begin
            key_busy <= 1'b1;
          end
        end

        // Long hold: release ends silently; optionally emit periodic repeats.
        LONG_HOLD: begin
          if (rel_ev) begin
            state    <= IDLE;
            cnt      <= '0;
            key_busy <= 1'b0;
          end
`ifdef KEY_EVENT_REPEAT_EN
          else if (cnt == REP_LAST) begin
            cnt          <= '0;
            repeat_pulse <= 1'b1;
            key_busy     <= 1'b1;
          end
`endif
          else begin
            cnt      <= cnt + CNT_ONE;
            key_busy <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          cnt      <= '0;
          key_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder: directed gesture scenarios with literal expectations, then random key traffic
// checked every cycle against a timestamp-based gesture model.
// Works with or without KEY_EVENT_REPEAT_EN defined.
module tb_key_event_decoder;

  localparam int LONG = 20;
  localparam int GAPC = 10;
  localparam int RPT  = 5;
  localparam int CW   = 8;
`ifdef KEY_EVENT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic key_flag = 1'b0;
  logic key_state = 1'b0;
  logic short_press, long_press, double_click, repeat_pulse, key_busy;

  key_event_decoder #(
    .LONG_CNT(LONG), .DBL_GAP_CNT(GAPC), .REPEAT_CNT(RPT), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Rst(Rst), .key_flag(key_flag), .key_state(key_state),
    .short_press(short_press), .long_press(long_press), .double_click(double_click),
    .repeat_pulse(repeat_pulse), .key_busy(key_busy)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Gesture model: tracks the gesture by timestamps of the key events rather than by counters.
  bit active = 1'b0;   // a gesture is in progress
  bit held = 1'b0;     // key currently down within the gesture
  bit second = 1'b0;   // second press of a double click seen
  bit in_long = 1'b0;  // long press already reported, key still down
  int t_down = 0;      // cycle of the gesture's first press
  int t_up = 0;        // cycle of the first release
  logic m_short = 1'b0, m_long = 1'b0, m_dbl = 1'b0, m_rep = 1'b0, m_busy = 1'b0;

  task automatic lit(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%b expected=%b", nm, act, exp);
    end
  endtask

  // Expected outputs for the cycle after inputs (f, s, r) were applied in cycle cyc.
  task automatic model(input bit f, input bit s, input bit r);
    bit pe, re;
    pe = f && !s;
    re = f && s;
    m_short = 1'b0; m_long = 1'b0; m_dbl = 1'b0; m_rep = 1'b0;
    if (r) begin
      active = 1'b0;
    end else if (!active) begin
      if (pe) begin
        active = 1'b1; held = 1'b1; second = 1'b0; in_long = 1'b0; t_down = cyc;
      end
    end else if (in_long) begin
      if (re) active = 1'b0;
      else if (REP && cyc > t_down + LONG && (cyc - t_down - LONG) % RPT == 0) m_rep = 1'b1;
    end else if (second) begin
      if (re) begin active = 1'b0; m_dbl = 1'b1; end
    end else if (held) begin
      if (re) begin held = 1'b0; t_up = cyc; end
      else if (cyc - t_down == LONG) begin in_long = 1'b1; m_long = 1'b1; end
    end else begin
      if (pe) begin second = 1'b1; held = 1'b1; end
      else if (cyc - t_up == GAPC) begin active = 1'b0; m_short = 1'b1; end
    end
    m_busy = active;
    cyc++;
  endtask

  task automatic tick(input bit f, input bit s, input bit r);
    key_flag = f; key_state = s; Rst = r;
    @(posedge Clk);
    model(f, s, r);
    @(negedge Clk);
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge Clk) begin
    if (chk_en) begin
      lit($sformatf("model short_press cyc%0d", cyc), short_press, m_short);
      lit($sformatf("model long_press cyc%0d", cyc), long_press, m_long);
      lit($sformatf("model double_click cyc%0d", cyc), double_click, m_dbl);
      lit($sformatf("model repeat_pulse cyc%0d", cyc), repeat_pulse, m_rep);
      lit($sformatf("model key_busy cyc%0d", cyc), key_busy, m_busy);
    end
  end

  // Directed gesture: event cycles relative to the first tick after a reset (-1 = none),
  // expected pulse cycles, repeat window, and up to two busy windows.
  task automatic play(input string nm, input int n,
                      input int p0, input int p1, input int r0, input int r1, input int rs,
                      input int e_short, input int e_long, input int e_dbl,
                      input int rep0, input int rep1,
                      input int b0, input int b1, input int b2, input int b3);
    tick(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < n; k++) begin
      bit pe, re, erep;
      int c;
      pe = (k == p0) || (k == p1);
      re = (k == r0) || (k == r1);
      tick(pe || re, re, k == rs);
      c = k + 1;
      erep = REP && rep0 >= 0 && c >= rep0 && c <= rep1 && (c - rep0) % RPT == 0;
      lit($sformatf("%s short_press c%0d", nm, c), short_press, c == e_short);
      lit($sformatf("%s long_press c%0d", nm, c), long_press, c == e_long);
      lit($sformatf("%s double_click c%0d", nm, c), double_click, c == e_dbl);
      lit($sformatf("%s repeat_pulse c%0d", nm, c), repeat_pulse, erep);
      lit($sformatf("%s key_busy c%0d", nm, c), key_busy,
          (c >= b0 && c <= b1) || (c >= b2 && c <= b3));
    end
  endtask

  initial begin
    tick(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    lit("reset short_press", short_press, 1'b0);
    lit("reset long_press", long_press, 1'b0);
    lit("reset double_click", double_click, 1'b0);
    lit("reset repeat_pulse", repeat_pulse, 1'b0);
    lit("reset key_busy", key_busy, 1'b0);

    //    name      n  p0 p1  r0  r1  rs  short long dbl rep0 rep1 busy windows
    play("short",  20, 0, -1,  5, -1, -1,  16,  -1, -1,  -1,  -1, 1, 15, -1, -1);
    play("double", 34, 0,  8,  4, 30, -1,  -1,  -1, 31,  -1,  -1, 1, 30, -1, -1);
    play("long",   44, 0, -1, 40, -1, -1,  -1,  21, -1,  26,  36, 1, 40, -1, -1);
    play("repeat", 48, 0, -1, 45, -1, -1,  -1,  21, -1,  26,  41, 1, 45, -1, -1);
    play("rel_p20",34, 0, -1, 20, -1, -1,  31,  -1, -1,  -1,  -1, 1, 30, -1, -1);
    play("prs_r10",22, 0, 15,  5, 18, -1,  -1,  -1, 19,  -1,  -1, 1, 18, -1, -1);
    play("rst_gap",24, 0,  9,  5, 11,  8,  22,  -1, -1,  -1,  -1, 1,  8, 10, 21);

    // Random key traffic at several event densities, with occasional resets.
    for (int blk = 0; blk < 18; blk++) begin
      int dens;
      dens = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 8 : 30);
      for (int k = 0; k < 200; k++) begin
        bit f, s, r;
        f = ($urandom_range(0, dens) == 0);
        s = ($urandom_range(0, 1) == 1);
        r = ($urandom_range(0, 299) == 0);
        tick(f, s, r);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
